// File: rtl/issue_stage_pkg.sv
// Shared types for the issue stage: decoded instruction bundle and FSM states.
// Build option WB_BYPASS_EN lets writebacks clear hazards in the same cycle.
package issue_stage_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_REG_AW   = 5;

    typedef struct packed {
        logic [31:0]           imm;
        logic [6:0]            op;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_REG_AW-1:0] rs1;
        logic [DEF_REG_AW-1:0] rs2;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic                  writes_rd;
    } decoded_instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } issue_state_e;

endpackage

// File: rtl/issue_stage_if.sv
// Dispatch-queue read port and execute handshake seen by the issue stage.
// master = issue stage side, slave = queue/execute side.
interface issue_stage_if;
    import issue_stage_pkg::*;

    logic           dq_empty;
    logic           dq_r_en;
    decoded_instr_t dq_instr;
    logic           ex_valid;
    logic           ex_ready;
    decoded_instr_t ex_instr;

    modport master (
        input  dq_empty, dq_instr, ex_ready,
        output dq_r_en, ex_valid, ex_instr
    );

    modport slave (
        output dq_empty, dq_instr, ex_ready,
        input  dq_r_en, ex_valid, ex_instr
    );

endinterface

// File: rtl/issue_stage_reg_scoreboard.sv
// Busy-register scoreboard: set on issue, clear on writeback, set wins.
// WB_BYPASS_EN masks the writeback target out of the lookup vector.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_rd,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_rd,
    input  logic [REG_AW-1:0]   rd_a,
    input  logic [REG_AW-1:0]   rd_b,
    output logic                hit_a,
    output logic                hit_b,
    output logic [NUM_REGS-1:0] busy_eff,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en && clr_rd != '0) clr_mask[clr_rd] = 1'b1;
        if (set_en && set_rd != '0) set_mask[set_rd] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

`ifdef WB_BYPASS_EN
    assign busy_eff = busy_q & ~clr_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign hit_a = busy_eff[rd_a];
    assign hit_b = busy_eff[rd_b];
    assign busy  = busy_q;

endmodule

// File: rtl/issue_stage.sv
// Issue stage: pops the dispatch queue, holds one instruction, issues on no hazard.
// Build option WB_BYPASS_EN: issue in the same cycle as the clearing writeback.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    issue_stage_if.master       bus,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [CNT_W-1:0]    stall_cnt
);

    issue_state_e        state_q, state_d;
    decoded_instr_t      hold_q;
    logic [CNT_W-1:0]    stall_q;
    logic                load;
    logic                pop;
    logic                offer;
    logic                issue;
    logic                hazard;
    logic                hit_rs1, hit_rs2;
    logic [NUM_REGS-1:0] busy_eff;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue && hold_q.writes_rd),
        .set_rd   (hold_q.rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .rd_a     (hold_q.rs1),
        .rd_b     (hold_q.rs2),
        .hit_a    (hit_rs1),
        .hit_b    (hit_rs2),
        .busy_eff (busy_eff),
        .busy     (busy_o)
    );

    assign hazard = (hold_q.uses_rs1 && hit_rs1)
                 || (hold_q.uses_rs2 && hit_rs2)
                 || (hold_q.writes_rd && busy_eff[hold_q.rd]);

    assign issue = offer && bus.ex_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        offer   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush && !bus.dq_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    offer = !hazard;
                    if (offer && bus.ex_ready) begin
                        // back-to-back pop keeps the 2-cycle cadence
                        pop     = !bus.dq_empty;
                        state_d = bus.dq_empty ? IDLE : LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (load)       hold_q <= bus.dq_instr;
            else if (flush) hold_q <= '0;
            if (state_q == HOLD && hazard && !flush
                && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.dq_r_en  = pop;
    assign bus.ex_valid = offer;
    assign bus.ex_instr = hold_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: queue model feeds the DUT, monitor checks issues.
// Build option WB_BYPASS_EN changes the expected writeback-to-issue timing.
module tb_issue_stage;
    import issue_stage_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] busy_o;
    logic [31:0] stall_cnt;

    int checks = 0;
    int fails  = 0;

    decoded_instr_t dq_mem [16];
    int head = 0;
    int tail = 0;
    decoded_instr_t expq [$];

    issue_stage_if bus();

    issue_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .busy_o    (busy_o),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    assign bus.dq_empty = (head == tail);

    always @(posedge clk) begin
        if (bus.dq_r_en) begin
            bus.dq_instr <= dq_mem[head % 16];
            head <= head + 1;
        end
    end

    // Monitor: every accepted issue must match the next expected instruction.
    always @(negedge clk) begin
        if (rst_n && bus.ex_valid && bus.ex_ready) begin
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: got %0h expected none",
                         bus.ex_instr);
            end else begin
                decoded_instr_t e;
                e = expq.pop_front();
                if (bus.ex_instr !== e) begin
                    fails++;
                    $display("FAIL issue_order: got %0h expected %0h",
                             bus.ex_instr, e);
                end
            end
        end
    end

    function automatic decoded_instr_t mk(
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic w, input logic [31:0] imm);
        decoded_instr_t i;
        i = '0;
        i.imm = imm;
        i.op = 7'h33;
        i.rd = rd;
        i.rs1 = rs1;
        i.rs2 = rs2;
        i.uses_rs1 = u1;
        i.uses_rs2 = u2;
        i.writes_rd = w;
        return i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input decoded_instr_t i, input bit exp);
        dq_mem[tail % 16] = i;
        tail++;
        if (exp) expq.push_back(i);
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd = r;
        cyc();
        wb_valid = 1'b0;
        wb_rd = '0;
    endtask

    initial begin
        decoded_instr_t i1, z, a, b, c, d, e, f, g, j;
`ifdef WB_BYPASS_EN
        decoded_instr_t h;
`endif
        logic [31:0] s0;
        rst_n = 1'b0;
        flush = 1'b0;
        wb_valid = 1'b0;
        wb_rd = '0;
        bus.ex_ready = 1'b0;
        #2;
        chk("rst_dq_r_en", 64'(bus.dq_r_en), 0);
        chk("rst_ex_valid", 64'(bus.ex_valid), 0);
        chk("rst_ex_instr", 64'(bus.ex_instr), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_stall", 64'(stall_cnt), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // single instr, rd=3
        i1 = mk(5'd3, 5'd0, 5'd0, 0, 0, 1, 32'h11);
        push(i1, 1);
        bus.ex_ready = 1'b1;
        #2 chk("t1_pop", 64'(bus.dq_r_en), 1);
        cyc();
        #2 chk("t1_load_pop", 64'(bus.dq_r_en), 0);
        chk("t1_load_valid", 64'(bus.ex_valid), 0);
        cyc();
        #2 chk("t1_hold_valid", 64'(bus.ex_valid), 1);
        chk("t1_hold_instr", 64'(bus.ex_instr), 64'(i1));
        cyc();
        #2 chk("t1_busy3", 64'(busy_o), 64'h8);
        chk("t1_idle_valid", 64'(bus.ex_valid), 0);
        wb(5'd3);
        #2 chk("t1_wb_clear", 64'(busy_o), 0);

        // rd=0 never becomes busy; wb_rd=0 ignored
        z = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 32'h22);
        push(z, 1);
        cyc();
        cyc();
        #2 chk("t3_valid", 64'(bus.ex_valid), 1);
        cyc();
        #2 chk("t3_busy", 64'(busy_o), 0);
        wb(5'd0);
        #2 chk("t3_wb0", 64'(busy_o), 0);

        // RAW on x5 with 4 stall cycles
        chk("t2_stall0", 64'(stall_cnt), 0);
        a = mk(5'd5, 5'd0, 5'd0, 0, 0, 1, 32'h33);
        b = mk(5'd6, 5'd5, 5'd0, 1, 0, 1, 32'h44);
        push(a, 1);
        push(b, 1);
        cyc();
        cyc();
        #2 chk("t2_a_valid", 64'(bus.ex_valid), 1);
        chk("t2_b2b_pop", 64'(bus.dq_r_en), 1);
        cyc();
        #2 chk("t2_busy5", 64'(busy_o), 64'h20);
        cyc();
        #2 chk("t2_hazard", 64'(bus.ex_valid), 0);
        cyc();
        cyc();
        cyc();
        cyc();
        wb_valid = 1'b1;
        wb_rd = 5'd5;
        #2 chk("t2_stall4", 64'(stall_cnt), 4);
        chk("t2_wb_cycle_valid", 64'(bus.ex_valid), 64'(BYP));
        cyc();
        wb_valid = 1'b0;
        wb_rd = '0;
        #2 chk("t2_stall_after", 64'(stall_cnt), BYP ? 64'd4 : 64'd5);
        chk("t2_after_valid", 64'(bus.ex_valid), BYP ? 64'd0 : 64'd1);
        chk("t2_after_busy", 64'(busy_o), BYP ? 64'h40 : 64'h0);
        cyc();
        #2 chk("t2_busy6", 64'(busy_o), 64'h40);
        wb(5'd6);

        // execute back-pressure for 3 cycles
        s0 = stall_cnt;
        c = mk(5'd8, 5'd1, 5'd0, 1, 0, 1, 32'h55);
        d = mk(5'd9, 5'd0, 5'd0, 0, 0, 1, 32'h66);
        push(c, 1);
        push(d, 1);
        bus.ex_ready = 1'b0;
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            #2 chk("t4_hold_valid", 64'(bus.ex_valid), 1);
            chk("t4_hold_instr", 64'(bus.ex_instr), 64'(c));
            chk("t4_hold_nopop", 64'(bus.dq_r_en), 0);
            if (k < 2) cyc();
        end
        bus.ex_ready = 1'b1;
        #1 chk("t4_release_pop", 64'(bus.dq_r_en), 1);
        cyc();
        cyc();
        #2 chk("t4_d_valid", 64'(bus.ex_valid), 1);
        cyc();
        #2 chk("t4_busy89", 64'(busy_o), 64'h300);
        chk("t4_stall_same", 64'(stall_cnt), 64'(s0));
        wb(5'd8);
        wb(5'd9);

        // flush in LOAD and in HOLD
        e = mk(5'd10, 5'd0, 5'd0, 0, 0, 1, 32'h77);
        f = mk(5'd11, 5'd0, 5'd0, 0, 0, 1, 32'h88);
        push(e, 0);
        push(f, 0);
        cyc();
        flush = 1'b1;
        #2 chk("t5_load_flush_pop", 64'(bus.dq_r_en), 0);
        chk("t5_load_flush_valid", 64'(bus.ex_valid), 0);
        cyc();
        flush = 1'b0;
        #2 chk("t5_idle_pop", 64'(bus.dq_r_en), 1);
        cyc();
        cyc();
        flush = 1'b1;
        #2 chk("t5_hold_flush_valid", 64'(bus.ex_valid), 0);
        chk("t5_hold_flush_pop", 64'(bus.dq_r_en), 0);
        cyc();
        flush = 1'b0;
        #2 chk("t5_idle_valid", 64'(bus.ex_valid), 0);
        chk("t5_idle_nopop", 64'(bus.dq_r_en), 0);
        chk("t5_busy", 64'(busy_o), 0);

        // issue rd=7 on the same edge as wb_rd=7: set wins
        g = mk(5'd7, 5'd0, 5'd0, 0, 0, 1, 32'h99);
        push(g, 1);
        cyc();
        cyc();
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        #2 chk("t6_valid", 64'(bus.ex_valid), 1);
        cyc();
        wb_valid = 1'b0;
        wb_rd = '0;
        #2 chk("t6_busy7", 64'(busy_o), 64'h80);
`ifdef WB_BYPASS_EN
        h = mk(5'd7, 5'd0, 5'd0, 0, 0, 1, 32'haa);
        push(h, 1);
        cyc();
        cyc();
        #2 chk("t6b_waw", 64'(bus.ex_valid), 0);
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        #1 chk("t6b_bypass", 64'(bus.ex_valid), 1);
        cyc();
        wb_valid = 1'b0;
        wb_rd = '0;
        #2 chk("t6b_busy7", 64'(busy_o), 64'h80);
`endif

        // async reset while holding
        bus.ex_ready = 1'b0;
        j = mk(5'd12, 5'd0, 5'd0, 0, 0, 1, 32'hbb);
        push(j, 0);
        cyc();
        cyc();
        #2 chk("t7_hold_valid", 64'(bus.ex_valid), 1);
        rst_n = 1'b0;
        #1 chk("t7_rst_valid", 64'(bus.ex_valid), 0);
        chk("t7_rst_instr", 64'(bus.ex_instr), 0);
        chk("t7_rst_busy", 64'(busy_o), 0);
        chk("t7_rst_stall", 64'(stall_cnt), 0);
        chk("t7_rst_pop", 64'(bus.dq_r_en), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #2 chk("t7_post_valid", 64'(bus.ex_valid), 0);

        cyc();
        cyc();
        chk("all_issued", 64'(expq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
